// File: rtl/hazard_pkg.sv
// Shared definitions for the hazard/sequencing controller: FSM state
// encoding, register specifier width and the default halt drain depth.
package hazard_pkg;

    localparam int REG_ADDR_W   = 3;
    localparam int DRAIN_CYCLES = 3;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_e;

endpackage

// File: rtl/hazard_ctrl_haz_detect.sv
// Source/destination comparator: flags a read-after-write hit when an
// enabled destination matches either valid ID-stage source specifier.
module haz_detect #(
    parameter int REG_ADDR_W = 3
) (
    input  logic                  rs_vld,
    input  logic [REG_ADDR_W-1:0] rs,
    input  logic                  rt_vld,
    input  logic [REG_ADDR_W-1:0] rt,
    input  logic                  dst_en,
    input  logic [REG_ADDR_W-1:0] dst,
    output logic                  raw_hit
);

    // Either source matching an enabled destination is a hit
    always_comb begin
        raw_hit = dst_en & ((rs_vld & (rs == dst)) | (rt_vld & (rt == dst)));
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller for the 5-stage core: load-use stalls,
// taken-branch squash, data-cache freeze and halt drain.
// Optional build macro HAZ_NOFWD_EN: no forwarding network, so any RAW
// against the EX or MEM destination stalls (not only loads).
module hazard_ctrl #(
    parameter int REG_ADDR_W   = hazard_pkg::REG_ADDR_W,
    parameter int DRAIN_CYCLES = hazard_pkg::DRAIN_CYCLES,
    parameter int CNT_W        = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_rs_vld,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic                  id_rt_vld,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_halt,
    input  logic                  ex_mem_rd,
    input  logic                  ex_reg_en,
    input  logic [REG_ADDR_W-1:0] ex_w1_reg,
    input  logic                  mem_reg_en,
    input  logic [REG_ADDR_W-1:0] mem_w1_reg,
    input  logic                  ex_br_taken,
    input  logic                  dmem_busy,
    output logic                  pc_hold,
    output logic                  if_id_hold,
    output logic                  if_id_flush,
    output logic                  id_ex_bubble,
    output logic                  pipe_freeze,
    output logic                  halted,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt
);

    import hazard_pkg::*;

    // Counter only needs to hold DRAIN_CYCLES-1 down to 0
    localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DW-1:0] DRAIN_INIT = DW'(DRAIN_CYCLES - 1);

    state_e          state_q, state_d;
    logic [DW-1:0]   drain_q, drain_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] flush_q, flush_d;

    logic ex_hit;
    logic raw_stall;

`ifdef HAZ_NOFWD_EN
    logic mem_hit;
    logic unused_ld;

    // Without forwarding, loads are no different from any other producer
    assign unused_ld = ex_mem_rd;

    haz_detect #(.REG_ADDR_W(REG_ADDR_W)) u_det_ex (
        .rs_vld (id_rs_vld),
        .rs     (id_rs),
        .rt_vld (id_rt_vld),
        .rt     (id_rt),
        .dst_en (ex_reg_en),
        .dst    (ex_w1_reg),
        .raw_hit(ex_hit)
    );

    haz_detect #(.REG_ADDR_W(REG_ADDR_W)) u_det_mem (
        .rs_vld (id_rs_vld),
        .rs     (id_rs),
        .rt_vld (id_rt_vld),
        .rt     (id_rt),
        .dst_en (mem_reg_en),
        .dst    (mem_w1_reg),
        .raw_hit(mem_hit)
    );

    assign raw_stall = ex_hit | mem_hit;
`else
    logic unused_mem;

    // Forwarding covers the MEM stage; only a load in EX forces a stall
    assign unused_mem = ^{mem_reg_en, mem_w1_reg};

    haz_detect #(.REG_ADDR_W(REG_ADDR_W)) u_det_ex (
        .rs_vld (id_rs_vld),
        .rs     (id_rs),
        .rt_vld (id_rt_vld),
        .rt     (id_rt),
        .dst_en (ex_reg_en & ex_mem_rd),
        .dst    (ex_w1_reg),
        .raw_hit(ex_hit)
    );

    assign raw_stall = ex_hit;
`endif

    // Control outputs, next state and counter updates by priority
    always_comb begin
        pc_hold      = 1'b0;
        if_id_hold   = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        pipe_freeze  = 1'b0;
        halted       = 1'b0;
        state_d      = state_q;
        drain_d      = drain_q;
        stall_d      = stall_q;
        flush_d      = flush_q;
        if (!rst) begin
            case (state_q)
                RUN: begin
                    if (dmem_busy) begin
                        pipe_freeze = 1'b1;
                        pc_hold     = 1'b1;
                        if_id_hold  = 1'b1;
                    end else if (ex_br_taken) begin
                        // Squash wins over anything sitting in ID
                        if_id_flush  = 1'b1;
                        id_ex_bubble = 1'b1;
                        flush_d      = flush_q + CNT_W'(1);
                    end else if (raw_stall) begin
                        pc_hold      = 1'b1;
                        if_id_hold   = 1'b1;
                        id_ex_bubble = 1'b1;
                    end else if (id_halt) begin
                        // HALT itself moves on into EX; nothing follows it
                        pc_hold     = 1'b1;
                        if_id_flush = 1'b1;
                        state_d     = DRAIN;
                        drain_d     = DRAIN_INIT;
                    end
                end
                DRAIN: begin
                    pc_hold     = 1'b1;
                    if_id_flush = 1'b1;
                    if (dmem_busy) begin
                        pipe_freeze = 1'b1;
                    end else if (drain_q == '0) begin
                        state_d = HALTED;
                    end else begin
                        drain_d = drain_q - DW'(1);
                    end
                end
                HALTED: begin
                    halted       = 1'b1;
                    pc_hold      = 1'b1;
                    if_id_hold   = 1'b1;
                    id_ex_bubble = 1'b1;
                end
                default: state_d = RUN;
            endcase
            if (pc_hold && (state_q != HALTED)) begin
                stall_d = stall_q + CNT_W'(1);
            end
        end
    end

    // FSM state, drain countdown and performance counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            drain_q <= '0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: table of single-cycle RUN vectors
// through a scoreboard queue, plus sequences for stall, drain and reset.
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_rs_vld, id_rt_vld, id_halt;
    logic [2:0]  id_rs, id_rt, ex_w1_reg, mem_w1_reg;
    logic        ex_mem_rd, ex_reg_en, mem_reg_en, ex_br_taken, dmem_busy;
    logic        pc_hold, if_id_hold, if_id_flush, id_ex_bubble, pipe_freeze, halted;
    logic [15:0] stall_cnt, flush_cnt;

    always #5 clk = ~clk;

    hazard_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .id_rs_vld   (id_rs_vld),
        .id_rs       (id_rs),
        .id_rt_vld   (id_rt_vld),
        .id_rt       (id_rt),
        .id_halt     (id_halt),
        .ex_mem_rd   (ex_mem_rd),
        .ex_reg_en   (ex_reg_en),
        .ex_w1_reg   (ex_w1_reg),
        .mem_reg_en  (mem_reg_en),
        .mem_w1_reg  (mem_w1_reg),
        .ex_br_taken (ex_br_taken),
        .dmem_busy   (dmem_busy),
        .pc_hold     (pc_hold),
        .if_id_hold  (if_id_hold),
        .if_id_flush (if_id_flush),
        .id_ex_bubble(id_ex_bubble),
        .pipe_freeze (pipe_freeze),
        .halted      (halted),
        .stall_cnt   (stall_cnt),
        .flush_cnt   (flush_cnt)
    );

    // Output pattern order: {pc_hold, if_id_hold, if_id_flush, id_ex_bubble, pipe_freeze, halted}
    localparam logic [5:0] O_IDLE  = 6'b000000;
    localparam logic [5:0] O_STALL = 6'b110100;
    localparam logic [5:0] O_FLUSH = 6'b001100;
    localparam logic [5:0] O_FRZ   = 6'b110010;
    localparam logic [5:0] O_HALT1 = 6'b101000;
    localparam logic [5:0] O_DRFRZ = 6'b101010;
    localparam logic [5:0] O_HLTD  = 6'b110101;
`ifdef HAZ_NOFWD_EN
    localparam logic [5:0] O_NOFWD = O_STALL;
`else
    localparam logic [5:0] O_NOFWD = O_IDLE;
`endif

    typedef struct packed {
        logic       rs_vld;
        logic [2:0] rs;
        logic       rt_vld;
        logic [2:0] rt;
        logic       halt;
        logic       mem_rd;
        logic       ex_en;
        logic [2:0] ex_w;
        logic       mem_en;
        logic [2:0] mem_w;
        logic       br;
        logic       busy;
        logic [5:0] exp;
    } vec_t;

    vec_t       vecs[13];
    logic [5:0] sb_q[$];
    int         vec_cnt  = 0;
    int         miss_cnt = 0;
    int         exp_stall = 0;
    int         exp_flush = 0;

    function automatic logic [5:0] outs();
        return {pc_hold, if_id_hold, if_id_flush, id_ex_bubble, pipe_freeze, halted};
    endfunction

    task automatic chk_o(input string nm, input logic [5:0] exp);
        vec_cnt++;
        if (outs() !== exp) begin
            miss_cnt++;
            $display("FAIL %s outs got=%b want=%b", nm, outs(), exp);
        end
    endtask

    task automatic chk_c(input string nm, input logic [15:0] got, input logic [15:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            miss_cnt++;
            $display("FAIL %s got=%0d want=%0d", nm, got, exp);
        end
    endtask

    task automatic cnt_chk(input string nm);
        chk_c({nm, "_stall_cnt"}, stall_cnt, 16'(exp_stall));
        chk_c({nm, "_flush_cnt"}, flush_cnt, 16'(exp_flush));
    endtask

    task automatic idle();
        id_rs_vld = 0; id_rs = 0; id_rt_vld = 0; id_rt = 0; id_halt = 0;
        ex_mem_rd = 0; ex_reg_en = 0; ex_w1_reg = 0;
        mem_reg_en = 0; mem_w1_reg = 0; ex_br_taken = 0; dmem_busy = 0;
    endtask

    task automatic load_use(input logic [2:0] r);
        ex_mem_rd = 1; ex_reg_en = 1; ex_w1_reg = r;
        id_rs_vld = 1; id_rs = r;
    endtask

    task automatic apply(input vec_t v);
        id_rs_vld = v.rs_vld; id_rs = v.rs; id_rt_vld = v.rt_vld; id_rt = v.rt;
        id_halt = v.halt; ex_mem_rd = v.mem_rd; ex_reg_en = v.ex_en; ex_w1_reg = v.ex_w;
        mem_reg_en = v.mem_en; mem_w1_reg = v.mem_w; ex_br_taken = v.br; dmem_busy = v.busy;
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic do_reset();
        idle();
        rst = 1;
        nxt();
        nxt();
        rst = 0;
        exp_stall = 0;
        exp_flush = 0;
    endtask

    function automatic vec_t mk(input logic rs_vld, input logic [2:0] rs,
                                input logic rt_vld, input logic [2:0] rt,
                                input logic halt, input logic mem_rd,
                                input logic ex_en, input logic [2:0] ex_w,
                                input logic mem_en, input logic [2:0] mem_w,
                                input logic br, input logic busy,
                                input logic [5:0] exp);
        vec_t v;
        v.rs_vld = rs_vld; v.rs = rs; v.rt_vld = rt_vld; v.rt = rt; v.halt = halt;
        v.mem_rd = mem_rd; v.ex_en = ex_en; v.ex_w = ex_w; v.mem_en = mem_en;
        v.mem_w = mem_w; v.br = br; v.busy = busy; v.exp = exp;
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        //          rsv rs   rtv rt   hlt ld  exen exw  men mw   br  busy exp
        vecs[0]  = mk(0, 3'd0, 0, 3'd0, 0, 0, 0, 3'd0, 0, 3'd0, 0, 0, O_IDLE);
        vecs[1]  = mk(1, 3'd1, 0, 3'd0, 0, 1, 1, 3'd1, 0, 3'd0, 0, 0, O_STALL);
        vecs[2]  = mk(0, 3'd0, 1, 3'd5, 0, 1, 1, 3'd5, 0, 3'd0, 0, 0, O_STALL);
        vecs[3]  = mk(0, 3'd1, 0, 3'd0, 0, 1, 1, 3'd1, 0, 3'd0, 0, 0, O_IDLE);
        vecs[4]  = mk(1, 3'd2, 1, 3'd3, 0, 1, 1, 3'd1, 0, 3'd0, 0, 0, O_IDLE);
        vecs[5]  = mk(1, 3'd4, 0, 3'd0, 0, 0, 1, 3'd4, 0, 3'd0, 0, 0, O_NOFWD);
        vecs[6]  = mk(1, 3'd6, 0, 3'd0, 0, 1, 0, 3'd6, 0, 3'd0, 0, 0, O_IDLE);
        vecs[7]  = mk(1, 3'd1, 0, 3'd0, 0, 1, 1, 3'd1, 0, 3'd0, 1, 0, O_FLUSH);
        vecs[8]  = mk(1, 3'd1, 0, 3'd0, 0, 1, 1, 3'd1, 0, 3'd0, 0, 1, O_FRZ);
        vecs[9]  = mk(0, 3'd0, 0, 3'd0, 0, 0, 0, 3'd0, 0, 3'd0, 1, 1, O_FRZ);
        vecs[10] = mk(0, 3'd0, 0, 3'd0, 1, 0, 0, 3'd0, 0, 3'd0, 1, 0, O_FLUSH);
        vecs[11] = mk(0, 3'd0, 0, 3'd0, 1, 0, 0, 3'd0, 0, 3'd0, 0, 1, O_FRZ);
        vecs[12] = mk(1, 3'd2, 0, 3'd0, 0, 0, 0, 3'd0, 1, 3'd2, 0, 0, O_NOFWD);

        // Reset state
        idle();
        rst = 1;
        #12;
        chk_o("reset_outs", O_IDLE);
        chk_c("reset_stall_cnt", stall_cnt, 16'd0);
        chk_c("reset_flush_cnt", flush_cnt, 16'd0);
        do_reset();

        // Single-cycle load-use bubble, then the load has moved on
        smp();
        chk_o("idle_after_reset", O_IDLE);
        nxt();
        load_use(3'd1);
        smp();
        chk_o("ld_use", O_STALL);
        exp_stall++;
        nxt();
        idle();
        smp();
        chk_o("ld_use_cleared", O_IDLE);
        cnt_chk("ld_use");

        // Table vectors through the scoreboard
        foreach (vecs[i]) begin
            logic [5:0] want;
            nxt();
            apply(vecs[i]);
            sb_q.push_back(vecs[i].exp);
            smp();
            want = sb_q.pop_front();
            chk_o($sformatf("vec%0d", i), want);
            if (want[5]) exp_stall++;
            if (want[3]) exp_flush++;
        end
        nxt();
        idle();
        smp();
        chk_o("table_tail_idle", O_IDLE);
        cnt_chk("table");

        // Cache busy for 4 cycles over a load-use, then the bubble
        for (int c = 0; c < 4; c++) begin
            nxt();
            load_use(3'd3);
            dmem_busy = 1;
            smp();
            chk_o($sformatf("busy_ld_use_c%0d", c), O_FRZ);
            exp_stall++;
        end
        nxt();
        dmem_busy = 0;
        smp();
        chk_o("busy_then_bubble", O_STALL);
        exp_stall++;
        nxt();
        idle();
        smp();
        chk_o("busy_seq_idle", O_IDLE);
        cnt_chk("busy_seq");

        // Halt drain: 3 drain cycles, branch in drain ignored, halted on the 4th
        do_reset();
        id_halt = 1;
        smp();
        chk_o("halt_in_run", O_HALT1);
        exp_stall++;
        nxt();
        id_halt = 0;
        for (int c = 1; c <= 3; c++) begin
            ex_br_taken = (c == 2);
            smp();
            chk_o($sformatf("drain_c%0d", c), O_HALT1);
            exp_stall++;
            nxt();
        end
        ex_br_taken = 0;
        smp();
        chk_o("halted_c4", O_HLTD);
        cnt_chk("halted_c4");
        nxt();
        load_use(3'd2);
        smp();
        chk_o("halted_sticky", O_HLTD);
        cnt_chk("halted_sticky");

        // Halt drain with 2 busy cycles: halted slips by 2
        do_reset();
        id_halt = 1;
        smp();
        exp_stall++;
        nxt();
        id_halt = 0;
        for (int c = 1; c <= 6; c++) begin
            dmem_busy = (c == 2) || (c == 3);
            smp();
            if (c < 6) begin
                chk_o($sformatf("drain_busy_c%0d", c), (c == 2 || c == 3) ? O_DRFRZ : O_HALT1);
                exp_stall++;
            end else begin
                chk_o("drain_busy_halted_c6", O_HLTD);
            end
            nxt();
        end
        dmem_busy = 0;
        cnt_chk("drain_busy");

        // Asynchronous reset mid-drain, with the cache busy
        do_reset();
        id_halt = 1;
        smp();
        nxt();
        id_halt = 0;
        dmem_busy = 1;
        smp();
        chk_o("pre_async_rst", O_DRFRZ);
        #1;
        rst = 1;
        #1;
        chk_o("async_rst_outs", O_IDLE);
        chk_c("async_rst_stall_cnt", stall_cnt, 16'd0);
        chk_c("async_rst_flush_cnt", flush_cnt, 16'd0);
        dmem_busy = 0;
        nxt();
        rst = 0;
        exp_stall = 0;
        exp_flush = 0;
        load_use(3'd7);
        smp();
        chk_o("after_rst_run", O_STALL);
        exp_stall++;
        nxt();
        idle();
        smp();
        chk_o("after_rst_idle", O_IDLE);
        cnt_chk("after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage 16-bit core. Drives stall, flush and bubble controls for the PC, IF/ID and ID/EX registers, and the freeze control for the EX/MEM and MEM/WB registers.
- Detects load-use RAW hazards, squashes wrong-path instructions on a taken branch, freezes the pipe while the data cache is busy, and drains the pipe on halt.
- Sits beside the ID/EX register. It sees ID-stage decode fields, ID/EX control outputs and the cache busy line.

Parameters:
- REG_ADDR_W, 3, register specifier width.
- DRAIN_CYCLES, 3, cycles after halt leaves ID before halted asserts (EX, MEM, WB).
- CNT_W, 16, width of stall/flush performance counters.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous active-high reset.
- id_rs_vld  in  1  ID instruction reads rs.
- id_rs  in  REG_ADDR_W  ID rs specifier.
- id_rt_vld  in  1  ID instruction reads second source.
- id_rt  in  REG_ADDR_W  ID second source specifier.
- id_halt  in  1  ID instruction is HALT.
- ex_mem_rd  in  1  ID/EX holds a load (mem_en & ~mem_wr).
- ex_reg_en  in  1  ID/EX writes a register.
- ex_w1_reg  in  REG_ADDR_W  ID/EX destination.
- mem_reg_en  in  1  EX/MEM writes a register.
- mem_w1_reg  in  REG_ADDR_W  EX/MEM destination.
- ex_br_taken  in  1  branch/jump resolved taken in EX.
- dmem_busy  in  1  cache miss/stall in progress.
- pc_hold  out  1  PC holds value.
- if_id_hold  out  1  IF/ID holds value.
- if_id_flush  out  1  IF/ID loads NOP.
- id_ex_bubble  out  1  ID/EX loads zero controls (NOP).
- pipe_freeze  out  1  EX/MEM and MEM/WB hold.
- halted  out  1  core stopped.
- stall_cnt  out  CNT_W  cycles with pc_hold=1.
- flush_cnt  out  CNT_W  taken-branch flush events.

Behaviour:
- States: RUN, DRAIN, HALTED. On rst: state=RUN, drain counter=0, stall_cnt=flush_cnt=0, halted=0.
- Controls are combinational from state and inputs. With idle inputs, all outputs are 0. rst asserted forces all controls to 0 immediately.
- Output priority in RUN, highest first:
  - dmem_busy: pipe_freeze=pc_hold=if_id_hold=1; id_ex_bubble=0; all else 0.
  - ex_br_taken: if_id_flush=1, id_ex_bubble=1, flush_cnt+1. A load-use or halt in ID is discarded.
  - load-use: ex_mem_rd & ex_reg_en & ((id_rs_vld & id_rs==ex_w1_reg) | (id_rt_vld & id_rt==ex_w1_reg)). Drives pc_hold=if_id_hold=id_ex_bubble=1 for exactly 1 cycle; the hazard clears once the load advances.
  - id_halt with none of the above: id_ex_bubble=0 (halt enters EX), pc_hold=1, if_id_flush=1. Next state DRAIN with counter=DRAIN_CYCLES-1.
- DRAIN: pc_hold=1, if_id_flush=1. Counter decrements each cycle without dmem_busy. dmem_busy freezes the pipe and the counter. When counter==0 and no dmem_busy, next state HALTED.
- HALTED: halted=1, pc_hold=if_id_hold=1, id_ex_bubble=1. Terminal until rst.
- ex_br_taken in DRAIN is ignored; halt is already past EX.
- Counters: stall_cnt increments every cycle pc_hold=1 in RUN or DRAIN. Both counters wrap modulo 2^CNT_W.
- rst mid-drain or mid-stall returns to RUN immediately and clears both counters.

Optional Feature:
- HAZ_NOFWD_EN defined: no forwarding network. Stall on any RAW against EX (ex_reg_en) or MEM (mem_reg_en) destination, not only loads. Same output pattern as load-use. Lasts until the producer reaches WB (up to 2 cycles).
- Undefined: only load-use stalls; mem_* inputs are unused.

Decomposition:
- Package hazard_pkg holds:
  - state encoding RUN=2'd0, DRAIN=2'd1, HALTED=2'd2;
  - REG_ADDR_W;
  - DRAIN_CYCLES default.
- One sub-module, haz_detect: purely combinational source/destination comparator producing raw_hit. Instantiated once for EX, and once more for MEM under HAZ_NOFWD_EN.

Test Plan:
- LD r1 in ID/EX (ex_mem_rd=1, ex_w1_reg=1), ADD reading id_rs=1 in ID -> exactly 1 cycle pc_hold=if_id_hold=id_ex_bubble=1, stall_cnt 0->1.
- Same load-use plus ex_br_taken=1 same cycle -> if_id_flush=id_ex_bubble=1, pc_hold=0, flush_cnt=1, stall_cnt unchanged.
- dmem_busy high 4 cycles during load-use -> pipe_freeze=1 for 4 cycles, no bubble. Then a 1-cycle load-use bubble; stall_cnt=5.
- id_halt in RUN -> DRAIN 3 cycles, halted=1 on 4th cycle. Inject dmem_busy 2 cycles in DRAIN -> halted delayed by 2.
- rst asserted asynchronously in DRAIN -> all outputs 0 before next clk edge, state RUN, counters 0.
- HAZ_NOFWD_EN: ADD r2 in EX/MEM, ID reads r2 -> 1 stall cycle. Undefined -> 0 stalls.
